fc_layer_tm: RTL and testbench
==============================

// Module: fc_layer_tm
// PURPOSE
//  Parametrised, time-multiplexed fully connected layer. LANES physical MACs serve NEURON_NUM
//  logical neurons in NEURON_NUM/LANES passes over one buffered input frame. Neuron outputs
//  leave as a valid/ready stream, so fc_layer_tm instances chain directly; weights/biases
//  load at runtime over the shared config bus.
// PARAMETERS
//  NEURON_NUM       30      logical neurons; must be a multiple of LANES
//  WEIGHT_NUM       784     inputs per frame = weights per neuron
//  DATA_WIDTH       16      signed data/weight/bias width
//  WEIGHT_INT_WIDTH 4       integer bits incl. sign; FRAC = DATA_WIDTH-WEIGHT_INT_WIDTH
//  LANES            10      physical MAC lanes
//  LAYER_NO         3       layer id matched against config_layer_num
//  ACT_TYPE         "relu"  "relu" or "linear"
// PORTS
//  clk               in   1           clock
//  rst               in   1           asynchronous reset, active-high
//  in_data           in   DATA_WIDTH  input sample, signed Q(WEIGHT_INT_WIDTH.FRAC)
//  in_valid          in   1           input sample valid
//  in_ready          out  1           layer accepts input
//  weight_value      in   32          weight; [DATA_WIDTH-1:0] used
//  weight_valid      in   1           weight write strobe
//  bias_value        in   32          bias; [DATA_WIDTH-1:0] used
//  bias_valid        in   1           bias write strobe
//  config_layer_num  in   32          target layer of config write
//  config_neuron_num in   32          target neuron of config write
//  out_data          out  DATA_WIDTH  neuron result, same Q format
//  out_valid         out  1           result valid
//  out_ready         in   1           downstream accepts
//  out_last          out  1           with out_valid: neuron NEURON_NUM-1 (frame end)
//  busy              out  1           frame in progress (state != LOAD or in_cnt != 0)
//  cfg_err           out  1           1-cycle pulse: config write dropped
// BEHAVIOUR
//  Reset: state=LOAD, in_cnt=0, pass=0, out_valid=0, out_last=0, in_ready=1, busy=0,
//   cfg_err=0, biases=0, weight wr_ptr=0. Weight RAM is not cleared; contents survive rst.
//  Storage: neuron n -> lane n%LANES, RAM addr (n/LANES)*WEIGHT_NUM+k. Sync RAM, 1-cycle read.
//  FSM LOAD: in_ready=1; each in_valid&in_ready writes buf[in_cnt++]. After WEIGHT_NUM
//   accepts -> COMPUTE, in_ready=0 from the next cycle.
//  FSM COMPUTE: k=0..WEIGHT_NUM-1, one per cycle. Pipeline: addr, read, multiply, accumulate.
//   Pass takes WEIGHT_NUM+3 cycles, then -> DRAIN.
//  FSM DRAIN: emit lane 0..LANES-1 results in order, one per out_valid&out_ready beat.
//   out_data/out_last stay stable while out_valid&!out_ready.
//   After last beat: pass++ -> COMPUTE; if last pass, pass=0 -> LOAD.
//   Min gap between frames: one idle cycle before in_ready=1.
//  Arithmetic: product 2*DATA_WIDTH signed.
//   acc width 2*DATA_WIDTH+clog2(WEIGHT_NUM), seeded with bias<<<FRAC.
//   result = acc>>>FRAC (arith, truncate), saturated to [0x8000..0x7FFF] (DW=16 case).
//   relu: negative -> 0 after saturation.
//  Config accepted only when state==LOAD and in_cnt==0, and config_layer_num==LAYER_NO.
//   Wrong layer: ignored silently.
//  weight_valid: write RAM[neuron, wr_ptr], wr_ptr++.
//   wr_ptr clears when config_neuron_num differs from the last accepted write's neuron.
//  bias_valid: write bias[config_neuron_num].
//  cfg_err pulses (write dropped) when any of these holds:
//   - write arrives while busy
//   - config_neuron_num >= NEURON_NUM
//   - wr_ptr == WEIGHT_NUM
//  Simultaneous weight_valid and bias_valid: both honoured.
//  rst mid-frame: all of the above reset values apply immediately; a partial frame is discarded.
// TESTING  (NEURON_NUM=4, WEIGHT_NUM=3, LANES=2, DATA_WIDTH=16, WEIGHT_INT_WIDTH=4; 1.0=0x1000)
//  1 Basic frame.
//    Stimulus: all weights 0x1000, biases 0, inputs 0x1000,0x2000,0x0800.
//    Response: 4 beats of 0x3800; out_last on 4th only; in_ready=1 again afterwards.
//  2 Relu clamp.
//    Stimulus: case 1 with neuron1 weights 0xF000.
//    Response: beat1=0x0000 under relu; 0xC800 with ACT_TYPE="linear".
//  3 Saturation.
//    Stimulus: weights 0x7FFF, inputs 0x7FFF.
//    Response: all beats 0x7FFF.
//    Stimulus: weights 0x8000, linear.
//    Response: all beats 0x8000.
//  4 Backpressure.
//    Stimulus: out_ready=0 for 5 cycles mid-DRAIN.
//    Response: out_data held stable; no lost or duplicated beat; in_ready=0 throughout.
//  5 Reset mid-COMPUTE.
//    Response: out_valid=0 and in_ready=1 at once; rerun of case 1 gives 0x3800 x4
//    (weights retained, biases 0).
//  6 Config checks.
//    Stimulus: weight write while busy.
//    Response: cfg_err pulse, later results unchanged.
//    Stimulus: config_layer_num=2.
//    Response: ignored, no cfg_err.
//    Stimulus: 4th weight to one neuron.
//    Response: cfg_err.

Source files
------------

// File: rtl/fc_layer_tm.sv
// fc_layer_tm
//   Time-multiplexed fully connected layer. LANES physical MACs evaluate
//   NEURON_NUM logical neurons in NEURON_NUM/LANES passes over one buffered
//   input frame. Results leave as a valid/ready stream, so instances chain.
//   Weights and biases are written at runtime over a shared config bus.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_data/in_valid/in_ready       input sample stream (signed Q(INT.FRAC))
//   weight_value/weight_valid       weight write (low DATA_WIDTH bits used)
//   bias_value/bias_valid           bias write (low DATA_WIDTH bits used)
//   config_layer_num                target layer of a config write
//   config_neuron_num               target neuron of a config write
//   out_data/out_valid/out_ready    neuron result stream, same Q format
//   out_last                        marks neuron NEURON_NUM-1 (frame end)
//   busy                            frame in progress
//   cfg_err                         one-cycle pulse: a config write was dropped
module fc_layer_tm #(
  parameter int    NEURON_NUM       = 30,
  parameter int    WEIGHT_NUM       = 784,
  parameter int    DATA_WIDTH       = 16,
  parameter int    WEIGHT_INT_WIDTH = 4,
  parameter int    LANES            = 10,
  parameter int    LAYER_NO         = 3,
  parameter string ACT_TYPE         = "relu"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           weight_value,
  input  logic                  weight_valid,
  input  logic [31:0]           bias_value,
  input  logic                  bias_valid,
  input  logic [31:0]           config_layer_num,
  input  logic [31:0]           config_neuron_num,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  cfg_err
);

  localparam int DW     = DATA_WIDTH;
  localparam int FRAC   = DW - WEIGHT_INT_WIDTH;
  localparam int PASSES = NEURON_NUM / LANES;
  localparam int DEPTH  = PASSES * WEIGHT_NUM;
  localparam int ACC_W  = 2 * DW + $clog2(WEIGHT_NUM);
  localparam int XW     = (WEIGHT_NUM > 1) ? $clog2(WEIGHT_NUM) : 1;
  localparam int CW     = $clog2(WEIGHT_NUM + 3);
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int NW     = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1;
  localparam int WPW    = $clog2(WEIGHT_NUM + 1);
  localparam bit IS_RELU = (ACT_TYPE == "relu");

  localparam logic signed [DW-1:0]    OUT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]    OUT_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(OUT_MAX);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(OUT_MIN);

  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

  state_t             state, state_nx;
  logic [XW-1:0]      in_cnt;
  logic [CW-1:0]      k_cnt;
  logic [PW-1:0]      pass;
  logic [LW-1:0]      d_cnt;
  logic               v1, v2;
  logic [AW-1:0]      raddr;
  logic signed [DW-1:0] in_buf [WEIGHT_NUM];
  logic signed [DW-1:0] rd_x;
  logic signed [DW-1:0] bias [NEURON_NUM];
  logic signed [DW-1:0] result [LANES];

  logic in_fire, in_last, k_last, beat, d_last, pass_last, seed;

  assign in_fire   = in_valid && (state == LOAD);
  assign in_last   = in_fire && (in_cnt == XW'(WEIGHT_NUM - 1));
  assign k_last    = (k_cnt == CW'(WEIGHT_NUM + 2));
  assign beat      = out_valid && out_ready;
  assign d_last    = (d_cnt == LW'(LANES - 1));
  assign pass_last = (pass == PW'(PASSES - 1));
  assign seed      = (state == COMPUTE) && (k_cnt == '0);
  assign raddr     = AW'(int'(pass) * WEIGHT_NUM + int'(k_cnt));

  // ---------------- FSM and stream outputs ----------------
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx  = state;
    in_ready  = (state == LOAD);
    out_valid = (state == DRAIN);
    out_last  = (state == DRAIN) && d_last && pass_last;
    busy      = (state != LOAD) || (in_cnt != '0);
    out_data  = result[d_cnt];
    unique case (state)
      LOAD:    if (in_last) state_nx = COMPUTE;
      COMPUTE: if (k_last)  state_nx = DRAIN;
      DRAIN:   if (beat && d_last) state_nx = pass_last ? LOAD : COMPUTE;
      default: state_nx = LOAD;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= LOAD;
      in_cnt <= '0;
      k_cnt  <= '0;
      pass   <= '0;
      d_cnt  <= '0;
      v1     <= 1'b0;
      v2     <= 1'b0;
    end else begin
      state <= state_nx;
      if (in_fire) in_cnt <= in_last ? '0 : in_cnt + 1'b1;
      if (state == COMPUTE) k_cnt <= k_last ? '0 : k_cnt + 1'b1;
      // v1: RAM/buffer read data valid, v2: product valid
      v1 <= (state == COMPUTE) && (k_cnt < CW'(WEIGHT_NUM));
      v2 <= v1;
      if (beat) begin
        d_cnt <= d_last ? '0 : d_cnt + 1'b1;
        if (d_last) pass <= pass_last ? '0 : pass + 1'b1;
      end
    end
  end

  // NOTE: the input buffer, weight RAM and MAC pipeline have no reset; the
  // data is qualified by in_cnt/v1/v2 and the bias seed, and weights must
  // survive rst.
  always_ff @(posedge clk) begin
    if (in_fire) in_buf[in_cnt] <= in_data;
    rd_x <= in_buf[k_cnt[XW-1:0]];
  end

  // ---------------- configuration bus ----------------
  logic             cfg_hit, n_ok, same_n, ptr_full, w_ok, b_ok, cfg_drop;
  logic [WPW-1:0]   wr_ptr, ptr_eff;
  logic [31:0]      last_neuron;
  logic [LW-1:0]    cfg_lane;
  logic [AW-1:0]    cfg_addr;

  assign cfg_hit  = (config_layer_num == 32'(LAYER_NO));
  assign n_ok     = (config_neuron_num < 32'(NEURON_NUM));
  assign same_n   = (config_neuron_num == last_neuron);
  // Switching to another neuron restarts its weight sequence at index 0.
  assign ptr_eff  = same_n ? wr_ptr : '0;
  assign ptr_full = (ptr_eff == WPW'(WEIGHT_NUM));
  assign w_ok     = cfg_hit && weight_valid && !busy && n_ok && !ptr_full;
  assign b_ok     = cfg_hit && bias_valid && !busy && n_ok;
  assign cfg_drop = cfg_hit && (weight_valid || bias_valid) &&
                    (busy || !n_ok || (weight_valid && ptr_full));
  assign cfg_lane = LW'(config_neuron_num % LANES);
  assign cfg_addr = AW'((config_neuron_num / LANES) * WEIGHT_NUM + 32'(ptr_eff));

  logic unused_cfg_bits;
  assign unused_cfg_bits = ^{weight_value[31:DW], bias_value[31:DW]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err     <= 1'b0;
      wr_ptr      <= '0;
      last_neuron <= '0;
      bias        <= '{default: '0};
    end else begin
      cfg_err <= cfg_drop;
      if (w_ok) begin
        wr_ptr      <= ptr_eff + 1'b1;
        last_neuron <= config_neuron_num;
      end
      if (b_ok) bias[NW'(config_neuron_num)] <= bias_value[DW-1:0];
    end
  end

  // ---------------- MAC lanes ----------------
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DW-1:0]    mem [DEPTH];
    logic signed [DW-1:0]    rd_w;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] acc, acc_sh;
    logic signed [DW-1:0]    sat;
    logic [NW-1:0]           bias_idx;

    assign bias_idx = NW'(int'(pass) * LANES + l);

    always_ff @(posedge clk) begin
      if (w_ok && (cfg_lane == LW'(l))) mem[cfg_addr] <= weight_value[DW-1:0];
      rd_w <= mem[raddr];
      prod <= rd_w * rd_x;
      if (seed)    acc <= ACC_W'(bias[bias_idx]) <<< FRAC;
      else if (v2) acc <= acc + ACC_W'(prod);
    end

    // Arithmetic shift truncates toward -inf before saturation.
    assign acc_sh = acc >>> FRAC;

    always_comb begin
      sat = acc_sh[DW-1:0];
      if (acc_sh > SAT_MAX)      sat = OUT_MAX;
      else if (acc_sh < SAT_MIN) sat = OUT_MIN;
    end

    assign result[l] = (IS_RELU && sat[DW-1]) ? '0 : sat;
  end

endmodule

// File: tb/tb_fc_layer_tm.sv
// Bench for fc_layer_tm: a relu and a linear instance share all stimulus;
// an arithmetic model of the layer predicts every output beat.
module tb_fc_layer_tm;

  localparam int NN   = 4;
  localparam int WN   = 3;
  localparam int FRAC = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic [31:0] weight_value, bias_value, config_layer_num, config_neuron_num;
  logic        weight_valid, bias_valid, out_ready;

  logic        in_ready_r, out_valid_r, out_last_r, busy_r, cfg_err_r;
  logic        in_ready_l, out_valid_l, out_last_l, busy_l, cfg_err_l;
  logic [15:0] out_data_r, out_data_l;

  always #5 clk = ~clk;

  fc_layer_tm #(.NEURON_NUM(NN), .WEIGHT_NUM(WN), .DATA_WIDTH(16), .WEIGHT_INT_WIDTH(4),
                .LANES(2), .LAYER_NO(3), .ACT_TYPE("relu")) dut_relu (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_r),
    .weight_value(weight_value), .weight_valid(weight_valid),
    .bias_value(bias_value), .bias_valid(bias_valid),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .out_data(out_data_r), .out_valid(out_valid_r), .out_ready(out_ready),
    .out_last(out_last_r), .busy(busy_r), .cfg_err(cfg_err_r));

  fc_layer_tm #(.NEURON_NUM(NN), .WEIGHT_NUM(WN), .DATA_WIDTH(16), .WEIGHT_INT_WIDTH(4),
                .LANES(2), .LAYER_NO(3), .ACT_TYPE("linear")) dut_lin (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
    .weight_value(weight_value), .weight_valid(weight_valid),
    .bias_value(bias_value), .bias_valid(bias_valid),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_last(out_last_l), .busy(busy_l), .cfg_err(cfg_err_l));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic signed [15:0] m_w [NN][WN];
  logic signed [15:0] m_b [NN];

  typedef struct {
    logic [15:0] r;
    logic [15:0] l;
    logic        lst;
  } beat_t;
  beat_t exp_q[$];

  function automatic logic [15:0] model_out(input int n, input logic signed [15:0] x [WN],
                                            input bit relu);
    longint acc;
    acc = longint'(m_b[n]) * 4096;
    for (int k = 0; k < WN; k++) acc += longint'(x[k]) * longint'(m_w[n][k]);
    acc = acc >>> FRAC;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    if (relu && acc < 0) acc = 0;
    return acc[15:0];
  endfunction

  // ---------------- compare process ----------------
  logic [15:0] cap_r [NN];
  logic [15:0] cap_l [NN];
  int          beat_idx;
  logic        prev_hold;
  logic [15:0] prev_r;
  logic        prev_last;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
      beat_idx  = 0;
    end else begin
      check("valid_pair", out_valid_l, out_valid_r);
      if (prev_hold) begin
        check("hold_valid", out_valid_r, 1);
        check("hold_data", out_data_r, prev_r);
        check("hold_last", out_last_r, prev_last);
      end
      if (out_valid_r && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat_queue", exp_q.size(), 1);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data_relu", out_data_r, e.r);
          check("beat_data_lin", out_data_l, e.l);
          check("beat_last_relu", out_last_r, e.lst);
          check("beat_last_lin", out_last_l, e.lst);
          cap_r[beat_idx % NN] = out_data_r;
          cap_l[beat_idx % NN] = out_data_l;
          beat_idx++;
        end
      end
      prev_hold = out_valid_r && !out_ready;
      prev_r    = out_data_r;
      prev_last = out_last_r;
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic cfg_write(input int layer, input int neuron, input logic [15:0] w, input bit wv,
                           input logic [15:0] b, input bit bv);
    config_layer_num  = layer;
    config_neuron_num = neuron;
    weight_value      = {16'h0000, w};
    bias_value        = {16'h0000, b};
    weight_valid      = wv;
    bias_valid        = bv;
    @(posedge clk); #1;
    weight_valid = 1'b0;
    bias_valid   = 1'b0;
  endtask

  task automatic load_neuron(input int n, input logic [15:0] w);
    for (int k = 0; k < WN; k++) begin
      cfg_write(3, n, w, 1'b1, 16'h0000, 1'b0);
      m_w[n][k] = w;
    end
  endtask

  task automatic load_all(input logic [15:0] w);
    for (int n = 0; n < NN; n++) load_neuron(n, w);
  endtask

  task automatic cfg_err_check(input string name, input logic exp);
    @(negedge clk);
    check({name, "_relu"}, cfg_err_r, exp);
    check({name, "_lin"}, cfg_err_l, exp);
    @(posedge clk); #1;
    check({name, "_pulse_end"}, cfg_err_r, 0);
  endtask

  task automatic send_frame(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2);
    logic signed [15:0] x [WN];
    int t;
    x[0] = x0; x[1] = x1; x[2] = x2;
    t = 0;
    while (!in_ready_r && t < 200) begin @(posedge clk); #1; t++; end
    check("in_ready_before_frame", in_ready_r, 1);
    for (int n = 0; n < NN; n++) begin
      beat_t e;
      e.r   = model_out(n, x, 1'b1);
      e.l   = model_out(n, x, 1'b0);
      e.lst = (n == NN - 1);
      exp_q.push_back(e);
    end
    for (int k = 0; k < WN; k++) begin
      in_data  = x[k];
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("in_ready_low_in_frame", in_ready_r, 0);
    check("busy_in_frame", busy_r, 1);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin @(posedge clk); #1; t++; end
    check({name, "_drained"}, exp_q.size(), 0);
    t = 0;
    while (!in_ready_r && t < 5) begin @(posedge clk); #1; t++; end
    check({name, "_in_ready_back"}, in_ready_r, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    weight_value = '0; bias_value = '0; weight_valid = 1'b0; bias_valid = 1'b0;
    config_layer_num = '0; config_neuron_num = '0;
    for (int n = 0; n < NN; n++) m_b[n] = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_in_ready", in_ready_r, 1);
    check("rst_out_valid", out_valid_r, 0);
    check("rst_out_last", out_last_r, 0);
    check("rst_busy", busy_r, 0);
    check("rst_cfg_err", cfg_err_r, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: basic frame, 1.0 + 2.0 + 0.5 = 3.5
    load_all(16'h1000);
    send_frame(16'h1000, 16'h2000, 16'h0800);
    wait_done("basic");
    check("basic_b0", cap_r[0], 16'h3800);
    check("basic_b3", cap_r[3], 16'h3800);

    // 2: negative neuron 1
    load_neuron(1, 16'hF000);
    send_frame(16'h1000, 16'h2000, 16'h0800);
    wait_done("relu");
    check("relu_b1_relu", cap_r[1], 16'h0000);
    check("relu_b1_lin", cap_l[1], 16'hC800);

    // bias -1.0 on neuron 3: 3.5 - 1.0 = 2.5
    cfg_write(3, 3, 16'h0000, 1'b0, 16'hF000, 1'b1);
    m_b[3] = 16'hF000;
    send_frame(16'h1000, 16'h2000, 16'h0800);
    wait_done("bias");
    check("bias_b3", cap_r[3], 16'h2800);

    // 3: saturation both ways
    load_all(16'h7FFF);
    send_frame(16'h7FFF, 16'h7FFF, 16'h7FFF);
    wait_done("sat_pos");
    check("sat_pos_b0", cap_r[0], 16'h7FFF);
    check("sat_pos_b3_lin", cap_l[3], 16'h7FFF);
    load_all(16'h8000);
    send_frame(16'h7FFF, 16'h7FFF, 16'h7FFF);
    wait_done("sat_neg");
    check("sat_neg_b0_lin", cap_l[0], 16'h8000);
    check("sat_neg_b2_relu", cap_r[2], 16'h0000);

    // 4: backpressure mid-drain
    load_all(16'h1000);
    send_frame(16'h1000, 16'h2000, 16'h0800);
    begin
      int t;
      t = 0;
      while (!out_valid_r && t < 100) begin @(posedge clk); #1; t++; end
      check("bp_reach_drain", out_valid_r, 1);
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (5) begin
        @(negedge clk);
        check("bp_in_ready_low", in_ready_r, 0);
        check("bp_valid_held", out_valid_r, 1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    wait_done("backpressure");
    check("bp_b1", cap_r[1], 16'h3800);

    // 6: config checks
    cfg_write(2, 0, 16'h7FFF, 1'b1, 16'h0000, 1'b0);
    cfg_err_check("wrong_layer", 1'b0);
    load_neuron(1, 16'h1000);
    cfg_write(3, 1, 16'h7FFF, 1'b1, 16'h0000, 1'b0);
    cfg_err_check("fourth_weight", 1'b1);
    cfg_write(3, 4, 16'h7FFF, 1'b1, 16'h0000, 1'b0);
    cfg_err_check("bad_neuron", 1'b1);
    // weight and bias together: neuron 2 gets bias 0.5 -> 4.0
    cfg_write(3, 2, 16'h1000, 1'b1, 16'h0800, 1'b1);
    m_w[2][0] = 16'h1000;
    m_b[2]    = 16'h0800;
    cfg_err_check("dual_write", 1'b0);
    send_frame(16'h1000, 16'h2000, 16'h0800);
    cfg_write(3, 0, 16'h7FFF, 1'b1, 16'h0000, 1'b0);
    cfg_err_check("busy_write", 1'b1);
    wait_done("config");
    check("config_b0", cap_r[0], 16'h3800);
    check("config_b2", cap_r[2], 16'h4000);

    // 5: reset mid-compute, weights retained, biases cleared
    send_frame(16'h1000, 16'h2000, 16'h0800);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid_r, 0);
    check("midrst_in_ready", in_ready_r, 1);
    check("midrst_busy", busy_r, 0);
    exp_q.delete();
    for (int n = 0; n < NN; n++) m_b[n] = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_frame(16'h1000, 16'h2000, 16'h0800);
    wait_done("rerun");
    check("rerun_b2", cap_r[2], 16'h3800);
    check("rerun_b3", cap_r[3], 16'h3800);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
